// File: rtl/mul_wb_sequencer_if.sv
// Bundles the operation request, the multiplier link, the register-file
// writeback port and the status outputs of mul_wb_sequencer.
interface mul_wb_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [3:0]  rdlo_addr;
    logic [3:0]  rdhi_addr;
    logic        setflags;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    logic [63:0] mul_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        done;
    logic        flags_valid;
    logic        flag_n;
    logic        flag_z;
    logic        err;

    modport master (
        output start, op, a, b, acc, rdlo_addr, rdhi_addr, setflags, mul_result, wb_ready,
        input  mul_a, mul_b, mul_signed, wb_valid, wb_addr, wb_data, busy, done,
               flags_valid, flag_n, flag_z, err
    );

    modport slave (
        input  start, op, a, b, acc, rdlo_addr, rdhi_addr, setflags, mul_result, wb_ready,
        output mul_a, mul_b, mul_signed, wb_valid, wb_addr, wb_data, busy, done,
               flags_valid, flag_n, flag_z, err
    );
endinterface

// File: rtl/mul_wb_sequencer.sv
// Multicycle sequencer around an external 32x32->64 multiplier: latches operands,
// accumulates, writes back RdLo/RdHi over a valid/ready port and produces N/Z flags.
module mul_wb_sequencer #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input logic                clk,
    input logic                reset,
    mul_wb_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {StIdle, StMult, StAcc, StWbLo, StWbHi, StDone} state_t;

    localparam logic [3:0] LatLoad = 4'(MUL_LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic [63:0] acc_q;
    logic [2:0]  op_q;
    logic [3:0]  lo_q, hi_q;
    logic        sf_q;
    logic [63:0] prod_q, sum_q;
    logic        err_q, err_d;
    logic        flag_n_q, flag_z_q;

    logic        accept, capture, flag_upd;
    logic        illegal, is_long;
    logic [63:0] addend;

    assign illegal = (bus.op[2:1] == 2'b01);
    assign is_long = op_q[2];

    always_comb begin
        case (op_q)
            3'b001:         addend = {32'b0, acc_q[31:0]};
            3'b101, 3'b111: addend = acc_q;
            default:        addend = 64'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        flag_upd = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = StMult;
                    end
                end
            end
            StMult: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StAcc;
                end
            end
            StAcc: state_d = StWbLo;
            StWbLo: begin
                if (bus.wb_ready) begin
                    if (is_long) begin
                        state_d = StWbHi;
                    end else begin
                        state_d  = StDone;
                        flag_upd = sf_q;
                    end
                end
            end
            StWbHi: begin
                if (bus.wb_ready) begin
                    state_d  = StDone;
                    flag_upd = sf_q;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_q    <= 64'd0;
            op_q     <= 3'd0;
            lo_q     <= 4'd0;
            hi_q     <= 4'd0;
            sf_q     <= 1'b0;
            prod_q   <= 64'd0;
            sum_q    <= 64'd0;
            err_q    <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (accept) begin
                cnt_q <= LatLoad;
                a_q   <= bus.a;
                b_q   <= bus.b;
                acc_q <= bus.acc;
                op_q  <= bus.op;
                lo_q  <= bus.rdlo_addr;
                hi_q  <= bus.rdhi_addr;
                sf_q  <= bus.setflags;
            end else if (state_q == StMult && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                prod_q <= bus.mul_result;
            end
            if (state_q == StAcc) begin
                sum_q <= prod_q + addend;
            end
            // Flags are committed on the final write so they are valid during DONE.
            if (flag_upd) begin
                flag_n_q <= is_long ? sum_q[63] : sum_q[31];
                flag_z_q <= is_long ? (sum_q == 64'd0) : (sum_q[31:0] == 32'd0);
            end
        end
    end

    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.mul_signed  = op_q[2] & op_q[1];
    assign bus.wb_valid    = (state_q == StWbLo) || (state_q == StWbHi);
    assign bus.wb_addr     = (state_q == StWbLo) ? lo_q :
                             (state_q == StWbHi) ? hi_q : 4'd0;
    assign bus.wb_data     = (state_q == StWbLo) ? sum_q[31:0] :
                             (state_q == StWbHi) ? sum_q[63:32] : 32'd0;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.flags_valid = (state_q == StDone) && sf_q;
    assign bus.flag_n      = flag_n_q;
    assign bus.flag_z      = flag_z_q;
    assign bus.err         = err_q;

endmodule
